// File: rtl/button_event.sv
// Gesture classifier fed by the debounced button level: emits one-cycle press,
// release, click, double-click and long-press pulses plus a registered held level.
// The release pulse is named release_pulse because "release" is a reserved word.
module button_event #(
   parameter int LONG_CYCLES = 1000,
   parameter int DOUBLE_GAP  = 250,
   parameter int CNT_W       = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       inp,
   output logic       held,
   output logic       press,
   output logic       release_pulse,
   output logic       click,
   output logic       double_click,
   output logic       long_press,
   output logic [2:0] fsm_state
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRESS1 = 3'd1,
      LONG   = 3'd2,
      WAIT2  = 3'd3,
      PRESS2 = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CYCLES);
   localparam logic [CNT_W-1:0] GAP_LIM  = CNT_W'(DOUBLE_GAP);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_inc;
   logic             inp_q;
   logic             rise;
   logic             fall;

   assign rise      = inp & ~inp_q;
   assign fall      = ~inp & inp_q;
   assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
   assign held      = inp_q;
   assign fsm_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         inp_q         <= 1'b0;
         press         <= 1'b0;
         release_pulse <= 1'b0;
         click         <= 1'b0;
         double_click  <= 1'b0;
         long_press    <= 1'b0;
      end else begin
         inp_q         <= inp;
         press         <= rise;
         release_pulse <= fall;
         click         <= 1'b0;
         double_click  <= 1'b0;
         long_press    <= 1'b0;

         case (state)
            IDLE: begin
               cnt <= '0;
               if (rise) begin
                  state <= PRESS1;
                  cnt   <= CNT_ONE;
               end
            end

            // The rising sample already counted as the first high sample.
            PRESS1: begin
               if (fall) begin
                  state <= WAIT2;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt_inc;
                  if (cnt_inc == LONG_LIM) begin
                     long_press <= 1'b1;
                     state      <= LONG;
                  end
               end
            end

            LONG: begin
               if (fall) begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            end

            // A rise on the sample that would close the window wins over click.
            WAIT2: begin
               if (rise) begin
                  if (cnt < GAP_LIM) begin
                     double_click <= 1'b1;
                     state        <= PRESS2;
                     cnt          <= '0;
                  end
               end else begin
                  cnt <= cnt_inc;
                  if (cnt_inc == GAP_LIM) begin
                     click <= 1'b1;
                     state <= IDLE;
                     cnt   <= '0;
                  end
               end
            end

            PRESS2: begin
               if (fall) begin
                  state <= IDLE;
                  cnt   <= '0;
               end
            end

            default: begin
               state <= IDLE;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/button_event.md
# button_event

Gesture classifier that sits directly downstream of the `debounce` stage. It consumes the clean, debounced button level and emits one-cycle event pulses: press, release, single click, double click and long press. It also provides a registered held level. Control logic such as menus and mode toggles consumes these pulses instead of raw levels.

## Interface
- `LONG_CYCLES`, default 1000: consecutive high samples that qualify a long press; must be ≥2.
- `DOUBLE_GAP`, default 250: maximum low samples after the first release within which a second press counts as a double click; must be ≥1.
- `CNT_W`, default 16: counter width; must hold max(`LONG_CYCLES`, `DOUBLE_GAP`).
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `inp` in 1: debounced button level (1 = pressed), driven by `debounce.out`.
- `held` out 1: registered copy of `inp`.
- `press` out 1: one-cycle pulse on every 0→1 transition.
- `release` out 1: one-cycle pulse on every 1→0 transition.
- `click` out 1: one-cycle pulse for a short single press not followed by a second press.
- `double_click` out 1: one-cycle pulse on the second press of a double click.
- `long_press` out 1: one-cycle pulse once a press has been held `LONG_CYCLES` samples.

## Operation
- `inp` is sampled every edge into `inp_q`; `held` = `inp_q`.
- Rise means sample 1 with previous 0. Fall means sample 0 with previous 1.
- All outputs are registered. Every pulse is high in the cycle after the sample that causes it.
- `press` and `release` fire on every rise and fall, independent of FSM state.
- State `IDLE`:
  - `cnt` = 0.
  - Rise → `PRESS1`, `cnt` = 1.
- State `PRESS1`:
  - Each high sample increments `cnt`.
  - When `cnt` reaches `LONG_CYCLES`, pulse `long_press` and go to `LONG`.
  - Fall before that → `WAIT2`, `cnt` = 0.
- State `LONG`:
  - Remain until fall → `IDLE`.
  - No click is generated.
- State `WAIT2`:
  - Each low sample increments `cnt`.
  - Rise while `cnt` < `DOUBLE_GAP` → pulse `double_click`, go to `PRESS2`.
  - When `cnt` reaches `DOUBLE_GAP` with no rise → pulse `click`, go to `IDLE`.
- State `PRESS2`:
  - Remain until fall → `IDLE`.
  - No long-press detection in this state.
- Counter saturates at its maximum and never wraps.
- A rise on the same sample that would complete the `WAIT2` window counts as a double click: `double_click` fires and `click` does not.
- `press` and `double_click` may be high in the same cycle.
- `release` and `long_press` are never high together, because `long_press` requires a high sample.

## Timing
- Reset values:
  - State `IDLE`, `cnt` = 0, `inp_q` = 0.
  - `held`, `press`, `release`, `click`, `double_click`, `long_press` all 0.
- Reset mid-operation: the sequence in progress is abandoned and no pulse is emitted for it.
- If `inp` is 1 at the first sample after `rst` falls, that sample is a rise and produces `press`.
- Latency from the causing `inp` sample is 1 cycle for:
  - `press` and `release`;
  - `long_press` (the `LONG_CYCLES`-th consecutive high sample);
  - `double_click` (the second rise);
  - `click` (the `DOUBLE_GAP`-th low sample after release).
- Minimum pulse spacing: 1 cycle. Events are not queued or merged.

## Test plan
Bench parameters: `LONG_CYCLES`=8, `DOUBLE_GAP`=4.

- **Reset:** hold `rst` with `inp`=0 → all outputs 0. Release `rst`, keep `inp`=0 for 20 cycles → no pulses.
- **Single click:** `inp` high 3 samples then low → `press` 1 cycle after rise, `release` 1 cycle after fall, `click` 1 cycle after the 4th low sample; no `long_press`, no `double_click`.
- **Long press:** `inp` high 12 samples → `long_press` exactly once, 1 cycle after the 8th high sample. On fall → `release` only; no `click`.
- **Double click:**
  - `inp` high 2, low 2, high 2, low → `double_click` coincident with the second `press`; no `click`. FSM returns to `IDLE` and the next isolated press behaves as a single click.
  - Boundary case: second rise on the 4th low sample → `double_click` fires, `click` does not.
  - Late case: second rise on the 5th low sample → `click` fires first, then the second press starts a new `PRESS1`.
- **Mid-operation reset:** press `inp` for 5 samples, assert `rst` for 1 cycle while `inp` stays high → no `long_press`. After reset, `press` fires on the first sample, and `long_press` fires 8 samples later.
